// File: rtl/imem_loader.sv
// Boot loader: parses a CNT/payload/CHK byte stream, writes instruction words
// into the instruction memory and releases the core reset once the image verifies.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// HDR_LO   | waiting for word-count low byte
// HDR_HI   | waiting for word-count high byte; range-checks the count
// DATA     | assembling little-endian words, one write per 4 bytes
// CHK      | comparing the received checksum with the running XOR
// DONE     | image verified; core released (terminal)
// ERR      | oversize count or checksum mismatch (terminal)
module imem_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROM_SIZE   = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  cpu_rst_n_o
);

    localparam logic [15:0] ROM_WORDS = 16'(ROM_SIZE);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [15:0]           widx_q, widx_d;
    logic [1:0]            lane_q, lane_d;
    logic [7:0]            xor_q, xor_d;
    logic [23:0]           part_q, part_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;

    logic                  accept;
    logic [15:0]           cnt_full;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        lane_d   = lane_q;
        xor_d    = xor_q;
        part_d   = part_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        accept   = byte_valid_i & ready_q;
        cnt_full = {byte_data_i, cnt_q[7:0]};

        if (accept) begin
            case (state_q)
                S_HDR_LO: begin
                    cnt_d   = {8'h00, byte_data_i};
                    xor_d   = xor_q ^ byte_data_i;
                    state_d = S_HDR_HI;
                end
                S_HDR_HI: begin
                    cnt_d = cnt_full;
                    xor_d = xor_q ^ byte_data_i;
                    if (cnt_full > ROM_WORDS) begin
                        state_d = S_ERR;
                    end else if (cnt_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    xor_d  = xor_q ^ byte_data_i;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: part_d[7:0]   = byte_data_i;
                        2'd1: part_d[15:8]  = byte_data_i;
                        2'd2: part_d[23:16] = byte_data_i;
                        default: begin
                            // Count was range-checked in HDR_HI; the index guard keeps
                            // the memory safe even if that ever changes.
                            if (widx_q < ROM_WORDS) begin
                                we_d    = 1'b1;
                                waddr_d = ADDR_WIDTH'({widx_q, 2'b00});
                                wdata_d = DATA_WIDTH'({byte_data_i, part_q});
                            end
                            widx_d = widx_q + 16'd1;
                            if (widx_q == cnt_q - 16'd1) begin
                                state_d = S_CHK;
                            end
                        end
                    endcase
                end
                S_CHK: begin
                    state_d = (byte_data_i == xor_q) ? S_DONE : S_ERR;
                end
                default: state_d = state_q;
            endcase
        end

        ready_d = (state_d != S_DONE) && (state_d != S_ERR);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HDR_LO;
            cnt_q   <= '0;
            widx_q  <= '0;
            lane_q  <= '0;
            xor_q   <= '0;
            part_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            lane_q  <= lane_d;
            xor_q   <= xor_d;
            part_q  <= part_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign cpu_rst_n_o  = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed stimulus for imem_loader, checked against a
// word-level model of the stream format (expected writes, outcome, timing).
module tb_imem_loader;

    localparam int ROM = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic        done_o;
    logic        err_o;
    logic        cpu_rst_n_o;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROM_SIZE(ROM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .cpu_rst_n_o  (cpu_rst_n_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Observed activity, stamped with the falling-edge index at which it was seen.
    int          ncyc = 0;
    int          acc_neg[$];
    int          w_neg_q[$];
    logic [31:0] w_addr_q[$];
    logic [31:0] w_data_q[$];
    int          first_done = -1;
    int          first_err  = -1;

    always @(negedge clk) begin
        ncyc++;
        if (we_o) begin
            w_neg_q.push_back(ncyc);
            w_addr_q.push_back(waddr_o);
            w_data_q.push_back(wdata_o);
        end
        if (done_o && first_done < 0) first_done = ncyc;
        if (err_o && first_err < 0) first_err = ncyc;
        if (byte_valid_i && byte_ready_o) acc_neg.push_back(ncyc);
    end

    task automatic mon_clear();
        acc_neg.delete();
        w_neg_q.delete();
        w_addr_q.delete();
        w_data_q.delete();
        first_done = -1;
        first_err  = -1;
    endtask

    logic [7:0]  stream_q[$];
    logic [31:0] words_q[$];

    task automatic drive_bytes(input int first, input int last, input int max_gap);
        for (int i = first; i < last; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                byte_valid_i = 1'b0;
                byte_data_i  = 8'($urandom);
                @(posedge clk); #2;
            end
            byte_valid_i = 1'b1;
            byte_data_i  = stream_q[i];
            @(posedge clk); #2;
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n        = 1'b0;
        byte_valid_i = 1'b0;
        #1;
        check("rst_ready", byte_ready_o, 0);
        check("rst_we", we_o, 0);
        check("rst_waddr", waddr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_cpu", cpu_rst_n_o, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_clear();
        repeat (2) @(posedge clk);
        #2;
    endtask

    // words_q must hold cnt words when cnt <= ROM.
    task automatic run_case(input string tag, input int cnt, input logic [7:0] chk_flip,
                            input int max_gap, input int pre_bytes);
        logic [7:0] x;
        bit         hdr_err;
        bit         exp_done;
        int         n_send;
        int         exp_writes;
        int         last_neg;

        hdr_err = (cnt > ROM);
        stream_q.delete();
        stream_q.push_back(cnt[7:0]);
        stream_q.push_back(cnt[15:8]);
        if (!hdr_err) begin
            for (int w = 0; w < cnt; w++)
                for (int b = 0; b < 4; b++) stream_q.push_back(words_q[w][8*b +: 8]);
            x = 8'h00;
            foreach (stream_q[i]) x = x ^ stream_q[i];
            stream_q.push_back(x ^ chk_flip);
        end
        n_send     = stream_q.size();
        exp_done   = !hdr_err && (chk_flip == 8'h00);
        exp_writes = hdr_err ? 0 : cnt;

        do_reset();
        if (pre_bytes > 0) begin
            drive_bytes(0, pre_bytes, max_gap);
            do_reset();
        end
        drive_bytes(0, n_send, max_gap);
        repeat (6) @(posedge clk);
        #2;

        check({tag, "_accepts"}, acc_neg.size(), n_send);
        check({tag, "_nwrites"}, w_addr_q.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < w_addr_q.size(); i++) begin
            check($sformatf("%s_waddr%0d", tag, i), w_addr_q[i], 4 * i);
            check($sformatf("%s_wdata%0d", tag, i), w_data_q[i], words_q[i]);
            if (acc_neg.size() > 2 + 4 * i + 3)
                check($sformatf("%s_wtime%0d", tag, i), w_neg_q[i], acc_neg[2 + 4 * i + 3] + 1);
        end
        check({tag, "_done"}, done_o, exp_done);
        check({tag, "_err"}, err_o, !exp_done);
        check({tag, "_cpu"}, cpu_rst_n_o, exp_done);
        check({tag, "_ready"}, byte_ready_o, 0);
        last_neg = (acc_neg.size() == n_send) ? acc_neg[n_send - 1] : -100;
        check({tag, "_tdone"}, first_done, exp_done ? last_neg + 1 : -1);
        check({tag, "_terr"}, first_err, exp_done ? -1 : last_neg + 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        words_q = '{32'h00000013, 32'h00100093};
        run_case("s1", 2, 8'h00, 0, 0);
        run_case("s1_badchk", 2, 8'h01, 0, 0);
        run_case("s1_gaps", 2, 8'h00, 5, 0);
        run_case("s1_rst", 2, 8'h00, 0, 6);
        run_case("cnt0", 0, 8'h00, 0, 0);
        run_case("cnt31", 31, 8'h00, 0, 0);

        words_q.delete();
        for (int i = 0; i < ROM; i++) words_q.push_back($urandom);
        run_case("cnt30", 30, 8'h00, 1, 0);

        for (int t = 0; t < 20; t++) begin
            int         cnt;
            logic [7:0] flip;
            cnt  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(31, 300)) : int'($urandom_range(0, ROM));
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            words_q.delete();
            for (int i = 0; i < ROM; i++) words_q.push_back($urandom);
            run_case($sformatf("rnd%0d", t), cnt, flip, int'($urandom_range(0, 3)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction ROM image. It consumes a byte stream carrying a header, little-endian instruction words and an XOR checksum. It issues one word write per instruction into instruction memory and holds the CPU core in reset until the image is complete and verified. It is the writer for the instruction memory's word-indexed read port: byte address / 4 selects the word.

## Interface
- ADDR_WIDTH, 32, width of `waddr_o`; byte address, word-aligned.
- DATA_WIDTH, 32, width of `wdata_o`; fixed at 32 (4 bytes per word).
- ROM_SIZE, 30, capacity of the instruction memory in words; maximum accepted word count.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- byte_valid_i  input  1  source presents a byte.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte; a transfer occurs when valid and ready are both high on a rising edge.
- we_o  output  1  one-cycle instruction-memory write strobe.
- waddr_o  output  ADDR_WIDTH  byte address of the write, equal to word_index*4.
- wdata_o  output  DATA_WIDTH  assembled instruction word.
- done_o  output  1  image loaded and checksum matched; sticky.
- err_o  output  1  oversize count or checksum mismatch; sticky.
- cpu_rst_n_o  output  1  active-low reset to the core; high only when done.

## Operation
- Stream format: CNT_LO, CNT_HI, then CNT×4 payload bytes, then CHK.
  - CNT is a 16-bit word count.
  - Each word is little-endian: the first byte goes to bits [7:0].
  - CHK is the XOR of every preceding byte, header included.
- States: HDR_LO → HDR_HI → DATA → CHK → DONE, with ERR as an extra terminal state.
  - Reset state is HDR_LO.
  - HDR_HI with CNT > ROM_SIZE → ERR.
  - HDR_HI with CNT == 0 → CHK.
  - Otherwise HDR_HI → DATA.
- DATA tracks two counters:
  - A 2-bit byte counter selects the byte lane of the word under assembly.
  - A 16-bit word index counts completed words.
  - On the 4th byte of a word, the word is written, the word index increments and the lane counter wraps to 0.
  - After word CNT−1 is written the FSM moves to CHK.
- CHK compares the received byte with the running XOR.
  - Match → DONE.
  - Mismatch → ERR.
- DONE and ERR are terminal until rst_n is asserted.
- byte_ready_o is high in HDR_LO, HDR_HI, DATA and CHK, and low in DONE and ERR. The loader never stalls the source while active.
- Bytes with byte_valid_i low are ignored. Idle gaps of any length between bytes are legal.
- Running XOR:
  - Cleared at reset.
  - Updated on every accepted header and payload byte.
  - Not updated by the CHK byte.
- CNT values above ROM_SIZE are rejected in HDR_HI. No write is ever issued with word_index ≥ ROM_SIZE.

## Timing
- Reset values while rst_n is low:
  - byte_ready_o=0, we_o=0, waddr_o=0, wdata_o=0
  - done_o=0, err_o=0, cpu_rst_n_o=0
  - state=HDR_LO, all counters and the XOR accumulator = 0
- byte_ready_o is registered. It rises on the first rising edge after rst_n deasserts.
- Write latency: we_o is high for exactly one cycle, on the cycle after the edge that accepts the 4th byte of a word.
  - waddr_o and wdata_o are valid in that same cycle.
  - Both hold their value until the next write.
- Back-to-back bytes at full rate give a write at most once every 4 cycles. The last write and the entry into CHK occur on the same edge.
- done_o and cpu_rst_n_o rise together, one cycle after the CHK byte is accepted with a match.
- err_o rises one cycle after the failing HDR_HI byte or CHK byte is accepted. byte_ready_o falls in that same cycle.
- Reset mid-stream immediately returns all outputs to their reset values. No partial write is issued, and the next stream starts at CNT_LO.

## Test plan
- CNT=2 with words 0x00000013 and 0x00100093, stream 02 00 13 00 00 00 93 00 10 00 92:
  - we_o pulses with (addr 0x0, data 0x00000013), then (0x4, 0x00100093).
  - done_o=1, cpu_rst_n_o=1, err_o=0.
- CNT=0, stream 00 00 00 → no writes; done_o=1, cpu_rst_n_o=1.
- CNT=31 (1F 00) → err_o=1 one cycle later, byte_ready_o=0, no we_o, cpu_rst_n_o stays 0.
- Scenario 1 with CHK=0x93 → both writes occur, then err_o=1, done_o=0, cpu_rst_n_o=0.
- Scenario 1 with random 0–5 cycle valid gaps between bytes → identical writes and done timing relative to the last byte.
- rst_n pulsed low after the 6th byte of scenario 1, then the full stream resent → only the two writes of the second pass after reset; done_o=1.
